// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO behind a TXDATA/STATUS register pair.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] CYC_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

`ifdef MMIO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
    localparam logic PAR_FLAG = 1'b1;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
    localparam logic PAR_FLAG = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [BW-1:0]     cyc_q, cyc_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        sh_q, sh_d;
    logic              tx_q, tx_d;
`ifdef MMIO_UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     cnt_q;
    logic              ovf_q;

    logic              push_req, push_ok, ovf_clr, empty, full, pop, last;
    logic [7:0]        head;
    logic [3:0]        cnt4;
    logic [31:0]       status;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == DEPTH_C);
    assign head     = mem_q[rp_q];
    assign last     = (cyc_q == CYC_LAST);
    assign push_req = MemWrite && (DataAdr == BASE_ADDR);
    assign push_ok  = push_req && !full;
    assign ovf_clr  = MemWrite && (DataAdr == BASE_ADDR + 32'd4) && WriteData[3];

    assign cnt4     = 4'(cnt_q);
    assign status   = {23'd0, PAR_FLAG, cnt4, ovf_q, state_q != S_IDLE, empty, full};
    assign ReadData = (DataAdr == BASE_ADDR + 32'd4) ? status : 32'd0;
    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE) || !empty;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != S_IDLE)
            cyc_d = last ? '0 : cyc_q + 1'b1;
        case (state_q)
            S_IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = S_START;
                sh_d    = head;
                tx_d    = 1'b0;
                cyc_d   = '0;
`ifdef MMIO_UART_TX_PARITY_EN
                par_d   = ^head;
`endif
            end
            S_START: if (last) begin
                state_d = S_DATA;
                bit_d   = 3'd0;
                tx_d    = sh_q[0];
            end
            // Shift register moves right so the next bit out is always sh_q[1].
            S_DATA: if (last) begin
                if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                    state_d = S_PARITY;
                    tx_d    = par_q;
`else
                    state_d = S_STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_d = bit_q + 3'd1;
                    sh_d  = sh_q >> 1;
                    tx_d  = sh_q[1];
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            S_PARITY: if (last) begin
                state_d = S_STOP;
                tx_d    = 1'b1;
            end
`endif
            S_STOP: if (last) begin
                if (!empty) begin
                    // Chain straight into the next start bit, no idle gap.
                    pop     = 1'b1;
                    state_d = S_START;
                    sh_d    = head;
                    tx_d    = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                end else begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wp_q] <= WriteData[7:0];
                wp_q        <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
            if (push_req && !push_ok) ovf_q <= 1'b1;
            else if (ovf_clr)         ovf_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-level reference model, directed then random stores.
// Honours MMIO_UART_TX_PARITY_EN the same way as the design.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int   NB  = 11;
    localparam logic PAR = 1'b1;
`else
    localparam int   NB  = 10;
    localparam logic PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = BASE + 32'd4;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        tx, busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queued bytes, current frame as a bit vector, cycle within frame.
    logic [7:0]  q[$];
    bit          act = 1'b0;
    logic [10:0] frm = '1;
    int          t = 0;
    bit          ovf = 1'b0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef MMIO_UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = (q.size() == DEPTH);
        s[1]   = (q.size() == 0);
        s[2]   = act;
        s[3]   = ovf;
        s[7:4] = 4'(q.size());
        s[8]   = PAR;
        return s;
    endfunction

    task automatic model_clear();
        q.delete();
        act = 1'b0;
        t   = 0;
        ovf = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        int pre;
        pre = q.size();
        if (act) begin
            t++;
            if (t == NB * CPB) act = 1'b0;
        end
        if (!act && pre > 0) begin
            frm = mk_frame(q.pop_front());
            act = 1'b1;
            t   = 0;
        end
        if (we && adr == BASE) begin
            if (pre < DEPTH) q.push_back(wd[7:0]);
            else             ovf = 1'b1;
        end
        if (we && adr == BASE + 32'd4 && wd[3]) ovf = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic [31:0] adr);
        check("tx", 32'(tx), act ? 32'(frm[t / CPB]) : 32'd1);
        check("busy", 32'(busy), 32'(act || q.size() > 0));
        check("rdata", ReadData, (adr == BASE + 32'd4) ? exp_status() : 32'd0);
    endtask

    task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wd;
        @(posedge clk);
        model_edge(we, adr, wd);
        #1;
        check_outputs(adr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, BASE + 32'd4, 32'd0);
    endtask

    // Reset lands between edges to exercise the asynchronous path.
    task automatic do_reset();
        MemWrite = 1'b0;
        DataAdr  = BASE + 32'd4;
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_status", ReadData, {23'd0, PAR, 8'h02});
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int r;
        logic [31:0] a;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_status", ReadData, {23'd0, PAR, 8'h02});
        reset = 1'b0;

        // Single byte 0x55 followed by drain.
        step(1'b1, BASE, 32'h0000_0055);
        idle(NB * CPB + 4);
        check("after_55_status", ReadData, {23'd0, PAR, 8'h02});

        // Back-to-back frames.
        step(1'b1, BASE, 32'h0000_00A5);
        step(1'b1, BASE, 32'h0000_003C);
        idle(2 * NB * CPB + 4);

        // Overflow: six stores, first popped right away, sixth rejected.
        for (int i = 0; i < 6; i++) step(1'b1, BASE, 32'(8'h10 + i));
        step(1'b0, BASE + 32'd4, 32'd0);
        check("ovf_cnt", 32'(ReadData[7:3]), 32'b01001);
        step(1'b1, BASE + 32'd4, 32'd8);
        check("ovf_clr", 32'(ReadData[3]), 32'd0);
        idle(5 * NB * CPB + 4);

        // Parity-relevant byte.
        step(1'b1, BASE, 32'h0000_0007);
        idle(NB * CPB + 4);

        // Reset mid-frame during data bit 3.
        step(1'b1, BASE, 32'h0000_0096);
        step(1'b1, BASE, 32'h0000_0011);
        idle(4 * CPB + 1);
        do_reset();
        idle(NB * CPB * 2);

        // Random traffic including out-of-window and misaligned accesses.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
            end else if (r < 30) begin
                step(1'b1, BASE, $urandom);
            end else if (r < 36) begin
                step(1'b1, BASE + 32'd4, $urandom);
            end else if (r < 44) begin
                case ($urandom_range(0, 3))
                    0:       a = BASE + 32'd1;
                    1:       a = BASE + 32'd8;
                    2:       a = 32'd0;
                    default: a = BASE + 32'h40 + 32'($urandom_range(0, 15) * 4);
                endcase
                step(1'b1, a, $urandom);
            end else if (r < 50) begin
                step(1'b0, BASE, 32'd0);
            end else begin
                step(1'b0, BASE + 32'd4, 32'd0);
            end
        end
        idle(DEPTH * NB * CPB + NB * CPB + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped serial output peripheral sitting on the core's data-memory bus beside dmem.
- Responder end of the store interface: consumes CPU stores (MemWrite/DataAdr/WriteData) to its address window.
- Buffers written bytes in a small FIFO and serializes them as 8N1 UART frames on tx.
- Exposes a readable status word so software can poll before storing.

Parameters:
- BASE_ADDR, 32'h0000_0100, word-aligned base of the 2-register window.
- CLKS_PER_BIT, 4, clock cycles per serial bit (>=2).
- FIFO_DEPTH, 4, byte FIFO entries; power of 2, >=2.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- MemWrite  input  1  store strobe from core
- DataAdr  input  32  byte address from core
- WriteData  input  32  store data from core
- ReadData  output  32  status read data, combinational on DataAdr
- tx  output  1  serial line, idle high, registered
- busy  output  1  high while frame in flight or FIFO non-empty

Behaviour:
- Register map:
  - BASE+0 TXDATA, write-only; WriteData[7:0] pushed.
  - BASE+4 STATUS: bit0 full, bit1 empty, bit2 shifting, bit3 overflow (sticky), bits[7:4] count, rest 0.
- ReadData = STATUS when DataAdr==BASE+4, else 0.
- Write to BASE+4 with WriteData[3]=1 clears overflow; other bits ignored.
- Push: MemWrite && DataAdr==BASE+0 sampled at rising edge. Accepted iff count<FIFO_DEPTH before that edge.
- Rejected push sets overflow; FIFO unchanged.
- Push and pop on the same edge: both take effect, count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE and FIFO non-empty at an edge: pop head into shift register, enter START; tx=0 from that edge.
  - Each state holds CLKS_PER_BIT cycles, counted by a bit-cycle counter.
  - DATA: 8 bits, LSB first, bit index 0..7.
  - STOP: tx=1. At its final cycle, go to START with a pop if FIFO non-empty (no idle gap between frames), else IDLE.
- Latency: store sampled at edge k -> pop at edge k+1 -> tx low from k+1.
  - Frame = 10*CLKS_PER_BIT cycles.
  - tx returns to idle-high after edge k+1+10*CLKS_PER_BIT if no further data.
- busy = (state!=IDLE) || !empty.
- Reset, anytime including mid-frame: state IDLE, tx=1, FIFO emptied (count 0), overflow 0, counters 0, busy=0.
- Addresses outside the window are ignored; no side effects.

Optional Feature:
- MMIO_UART_TX_PARITY_EN
- Defined: PARITY state between DATA and STOP emits even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT; STATUS bit8 reads 1.
- Undefined: no PARITY state, 10-bit frame, STATUS bit8 = 0.

Test Plan:
- Reset then idle: tx=1, busy=0, read BASE+4 -> 32'h0000_0002.
- Store 0x55 to BASE+0, CLKS_PER_BIT=4: tx sequence 0,1,0,1,0,1,0,1,0,1 each held 4 cycles; busy falls after 40 cycles; STATUS returns 32'h2.
- Store 0xA5, 0x3C on consecutive cycles: two frames back-to-back, 80 cycles, no idle-high gap between stop and next start; decoded bytes A5 then 3C.
- Six stores with a blocked start (FIFO_DEPTH=4, first byte popped immediately): 5 accepted, 6th dropped, STATUS bit3=1, count=4. Store WriteData=8 to BASE+4 clears bit3.
- Assert reset at bit 3 of a frame: tx=1 same cycle (async); FIFO empty; no further frames after reset deassert.
- With MMIO_UART_TX_PARITY_EN, store 0x07: parity bit=1 after data, frame 44 cycles; STATUS bit8=1.
